// File: rtl/irrigation_pkg.sv
// rtl/irrigation_pkg.sv - state and irrigation-type encodings shared with the timer encoder
package irrigation_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PURGE    = 2'b01,
    ST_IRRIGATE = 2'b10,
    ST_SETTLE   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    TYPE_NONE      = 2'b00,
    TYPE_DRIP      = 2'b01,
    TYPE_SPRINKLER = 2'b10,
    TYPE_MIXED     = 2'b11
  } type_t;

  localparam int GUARD_W = 4;

endpackage

// File: rtl/input_sync.sv
// rtl/input_sync.sv - N-stage synchronizer, optionally reduced to a rising-edge pulse
module input_sync #(
  parameter int STAGES    = 2,
  parameter bit RISE_EDGE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;
  logic [STAGES:0]   chain_in;

  assign chain_in = {chain, d};

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= chain_in[STAGES-1:0];
    end
  end

  generate
    if (RISE_EDGE) begin : g_rise
      logic last;

      // Remember the previous synchronized level to form an edge pulse
      always_ff @(posedge clk) begin
        if (reset) begin
          last <= 1'b0;
        end else begin
          last <= chain[STAGES-1];
        end
      end

      assign q = chain[STAGES-1] & ~last;
    end else begin : g_level
      assign q = chain[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/irrigation_controller.sv
// rtl/irrigation_controller.sv - purge/irrigate/settle sequencer driving the irrigation timer; optional watchdog via CTRL_WATCHDOG_EN
module irrigation_controller
  import irrigation_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int GUARD_CYCLES = 2
`ifdef CTRL_WATCHDOG_EN
  , parameter int WDOG_CYCLES = 4096
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       moisture_dry,
  input  logic       tank_low,
  input  logic [1:0] type_sel,
  input  logic       timer_done,
  output logic [1:0] state,
  output logic [1:0] irrigation_type,
  output logic       pulse_transiction,
  output logic       init_pulse,
  output logic       valve_main,
  output logic       valve_purge,
  output logic       pump_on,
  output logic       busy,
  output logic       fault
);

  logic start_rise;
  logic stop_s;
  logic dry_s;
  logic tank_s;

  input_sync #(.STAGES(SYNC_STAGES), .RISE_EDGE(1'b1)) u_sync_start (
    .clk(clk), .reset(reset), .d(start), .q(start_rise)
  );
  input_sync #(.STAGES(SYNC_STAGES), .RISE_EDGE(1'b0)) u_sync_stop (
    .clk(clk), .reset(reset), .d(stop), .q(stop_s)
  );
  input_sync #(.STAGES(SYNC_STAGES), .RISE_EDGE(1'b0)) u_sync_dry (
    .clk(clk), .reset(reset), .d(moisture_dry), .q(dry_s)
  );
  input_sync #(.STAGES(SYNC_STAGES), .RISE_EDGE(1'b0)) u_sync_tank (
    .clk(clk), .reset(reset), .d(tank_low), .q(tank_s)
  );

  state_t             st_q;
  state_t             st_n;
  logic [1:0]         type_n;
  logic               fault_n;
  logic               load;
  logic [GUARD_W-1:0] guard_q;
  logic [GUARD_W-1:0] guard_n;
  logic               qual_done;
  logic               wd_expired;

  // The timer's clk_off is stale right after a load, so it only counts once the guard has drained
  assign qual_done = timer_done && (guard_q == '0);
  assign state     = st_q;

`ifdef CTRL_WATCHDOG_EN
  localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [WD_W-1:0] wd_q;

  assign wd_expired = (wd_q == WD_W'(WDOG_CYCLES - 1));

  // Count cycles spent in the current timed state; restarts on every load
  always_ff @(posedge clk) begin
    if (reset || load || (st_n == ST_IDLE)) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  // Next-state, latched type, fault and load strobe; abort beats timer_done beats watchdog
  always_comb begin
    st_n    = st_q;
    type_n  = irrigation_type;
    fault_n = fault;
    load    = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (start_rise && dry_s) begin
          if (tank_s || (type_sel == TYPE_NONE)) begin
            fault_n = 1'b1;
          end else begin
            type_n  = type_sel;
            fault_n = 1'b0;
            load    = 1'b1;
            st_n    = ST_PURGE;
          end
        end
      end
      ST_PURGE, ST_IRRIGATE: begin
        if (stop_s || tank_s) begin
          st_n = ST_SETTLE;
          load = 1'b1;
          if (tank_s) begin
            fault_n = 1'b1;
          end
        end else if (qual_done) begin
          st_n = (st_q == ST_PURGE) ? ST_IRRIGATE : ST_SETTLE;
          load = 1'b1;
        end else if (wd_expired) begin
          st_n    = ST_IDLE;
          fault_n = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (qual_done) begin
          st_n = ST_IDLE;
        end else if (wd_expired) begin
          st_n    = ST_IDLE;
          fault_n = 1'b1;
        end
      end
      default: begin
        st_n = ST_IDLE;
      end
    endcase

    if (load) begin
      guard_n = GUARD_W'(GUARD_CYCLES);
    end else if (guard_q != '0) begin
      guard_n = guard_q - 1'b1;
    end else begin
      guard_n = guard_q;
    end
  end

  // Register state and every output so actuators and strobes move on the same edge as state
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q              <= ST_IDLE;
      irrigation_type   <= 2'b00;
      pulse_transiction <= 1'b0;
      init_pulse        <= 1'b0;
      valve_main        <= 1'b0;
      valve_purge       <= 1'b0;
      pump_on           <= 1'b0;
      busy              <= 1'b0;
      fault             <= 1'b0;
      guard_q           <= '0;
    end else begin
      st_q              <= st_n;
      irrigation_type   <= type_n;
      pulse_transiction <= load;
      init_pulse        <= load;
      valve_main        <= (st_n == ST_IRRIGATE);
      valve_purge       <= (st_n == ST_PURGE);
      pump_on           <= (st_n == ST_PURGE) || (st_n == ST_IRRIGATE);
      busy              <= (st_n != ST_IDLE);
      fault             <= fault_n;
      guard_q           <= guard_n;
    end
  end

endmodule

// File: tb/tb_irrigation_controller.sv
// tb/tb_irrigation_controller.sv - self-checking bench for irrigation_controller
module tb_irrigation_controller;
  import irrigation_pkg::*;

  localparam int SYNC_STAGES  = 2;
  localparam int GUARD_CYCLES = 2;
  localparam int LAT          = SYNC_STAGES + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       moisture_dry;
  logic       tank_low;
  logic [1:0] type_sel;
  logic       timer_done;
  logic [1:0] state;
  logic [1:0] irrigation_type;
  logic       pulse_transiction;
  logic       init_pulse;
  logic       valve_main;
  logic       valve_purge;
  logic       pump_on;
  logic       busy;
  logic       fault;

  int         passed = 0;
  int         total  = 0;
  int         failed = 0;
  logic       exp_fault;
  logic [1:0] exp_type;

  irrigation_controller #(
    .SYNC_STAGES(SYNC_STAGES),
    .GUARD_CYCLES(GUARD_CYCLES)
`ifdef CTRL_WATCHDOG_EN
    , .WDOG_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .moisture_dry(moisture_dry), .tank_low(tank_low), .type_sel(type_sel),
    .timer_done(timer_done), .state(state), .irrigation_type(irrigation_type),
    .pulse_transiction(pulse_transiction), .init_pulse(init_pulse),
    .valve_main(valve_main), .valve_purge(valve_purge), .pump_on(pump_on),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full output snapshot: actuators follow from the phase by the spec's rules
  task automatic chk_st(input string tag, input logic [1:0] st, input logic strobe);
    chk({tag, " state"}, 32'(state), 32'(st));
    chk({tag, " pulse_transiction"}, 32'(pulse_transiction), 32'(strobe));
    chk({tag, " init_pulse"}, 32'(init_pulse), 32'(strobe));
    chk({tag, " valve_purge"}, 32'(valve_purge), 32'(st == 2'b01));
    chk({tag, " valve_main"}, 32'(valve_main), 32'(st == 2'b10));
    chk({tag, " pump_on"}, 32'(pump_on), 32'((st == 2'b01) || (st == 2'b10)));
    chk({tag, " busy"}, 32'(busy), 32'(st != 2'b00));
    chk({tag, " fault"}, 32'(fault), 32'(exp_fault));
    chk({tag, " irrigation_type"}, 32'(irrigation_type), 32'(exp_type));
  endtask

  // Raise start after a quiet gap; returns on the edge where the FSM acts on it
  task automatic do_start();
    start = 1'b0;
    tick(LAT + 1);
    start = 1'b1;
    tick(LAT);
    start = 1'b0;
  endtask

  // Stay in cur for w cycles, then one timer_done pulse moves to nxt
  task automatic run_phase(input string tag, input logic [1:0] cur, input logic [1:0] nxt, input int w);
    timer_done = 1'b0;
    for (int i = 0; i < w; i++) begin
      tick(1);
      chk_st({tag, " hold"}, cur, 1'b0);
    end
    timer_done = 1'b1;
    tick(1);
    timer_done = 1'b0;
    chk_st({tag, " advance"}, nxt, nxt != 2'b00);
  endtask

  // After w cycles in cur, raise stop or tank_low; SETTLE follows LAT edges later
  task automatic abort_phase(input string tag, input logic [1:0] cur, input int w, input bit use_tank);
    for (int i = 0; i < w; i++) begin
      tick(1);
      chk_st({tag, " pre"}, cur, 1'b0);
    end
    if (use_tank) tank_low = 1'b1;
    else stop = 1'b1;
    tick(LAT - 1);
    chk_st({tag, " sync"}, cur, 1'b0);
    tick(1);
    stop     = 1'b0;
    tank_low = 1'b0;
    if (use_tank) exp_fault = 1'b1;
    chk_st({tag, " settle"}, ST_SETTLE, 1'b1);
  endtask

  task automatic valid_start(input string tag, input logic [1:0] ty);
    type_sel     = ty;
    moisture_dry = 1'b1;
    tank_low     = 1'b0;
    do_start();
    exp_fault = 1'b0;
    exp_type  = ty;
    chk_st({tag, " enter"}, ST_PURGE, 1'b1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; moisture_dry = 1'b0;
    tank_low = 1'b0; type_sel = 2'b00; timer_done = 1'b0;
    exp_fault = 1'b0; exp_type = 2'b00;
    tick(3);
    reset = 1'b0;
    chk_st("reset", ST_IDLE, 1'b0);

    // Normal cycle, sprinkler, timer_done after 8 cycles per phase
    valid_start("normal", TYPE_SPRINKLER);
    run_phase("normal purge", ST_PURGE, ST_IRRIGATE, 7);
    run_phase("normal irrigate", ST_IRRIGATE, ST_SETTLE, 7);
    run_phase("normal settle", ST_SETTLE, ST_IDLE, 7);
    tick(1);
    chk_st("normal idle", ST_IDLE, 1'b0);

    // timer_done in IDLE has no effect
    timer_done = 1'b1;
    tick(4);
    timer_done = 1'b0;
    chk_st("idle done", ST_IDLE, 1'b0);

    // Start qualification: wet soil ignored, low tank and invalid type fault
    type_sel = TYPE_DRIP; moisture_dry = 1'b0;
    do_start(); tick(1);
    chk_st("wet start", ST_IDLE, 1'b0);
    moisture_dry = 1'b1; tank_low = 1'b1;
    do_start(); exp_fault = 1'b1;
    chk_st("tank start", ST_IDLE, 1'b0);
    tick(1);
    chk_st("tank start after", ST_IDLE, 1'b0);
    tank_low = 1'b0; moisture_dry = 1'b0;
    do_start(); tick(1);
    chk_st("wet keeps fault", ST_IDLE, 1'b0);
    valid_start("clear", TYPE_DRIP);
    abort_phase("clear stop", ST_PURGE, 2, 1'b0);
    run_phase("clear settle", ST_SETTLE, ST_IDLE, 3);
    type_sel = TYPE_NONE;
    do_start(); exp_fault = 1'b1;
    chk_st("type0 start", ST_IDLE, 1'b0);

    // Guard window: timer_done held from PURGE entry is ignored GUARD_CYCLES cycles
    valid_start("guard", TYPE_MIXED);
    timer_done = 1'b1;
    for (int i = 0; i < GUARD_CYCLES; i++) begin
      tick(1);
      chk_st("guard hold", ST_PURGE, 1'b0);
    end
    tick(1);
    timer_done = 1'b0;
    chk_st("guard expire", ST_IRRIGATE, 1'b1);

    // tank_low coinciding with timer_done in IRRIGATE: abort wins, fault set
    tick(3);
    chk_st("tank pre", ST_IRRIGATE, 1'b0);
    tank_low = 1'b1;
    tick(LAT - 1);
    chk_st("tank sync", ST_IRRIGATE, 1'b0);
    timer_done = 1'b1;
    tick(1);
    timer_done = 1'b0;
    exp_fault  = 1'b1;
    chk_st("tank abort", ST_SETTLE, 1'b1);
    tick(4);
    chk_st("tank ignored in settle", ST_SETTLE, 1'b0);
    tank_low = 1'b0;
    run_phase("tank settle", ST_SETTLE, ST_IDLE, 2);
    tick(1);
    chk_st("fault sticky", ST_IDLE, 1'b0);
    valid_start("fault clear", TYPE_DRIP);
    run_phase("fc purge", ST_PURGE, ST_IRRIGATE, 3);

    // Start edge outside IDLE is ignored
    do_start();
    chk_st("start in irrigate", ST_IRRIGATE, 1'b0);

    // Reset held 3 cycles mid-IRRIGATE
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    exp_fault = 1'b0; exp_type = 2'b00;
    chk_st("mid reset", ST_IDLE, 1'b0);

    // Watchdog: PURGE with no timer_done
    valid_start("wdog", TYPE_SPRINKLER);
`ifdef CTRL_WATCHDOG_EN
    for (int i = 0; i < 15; i++) begin
      tick(1);
      chk_st("wdog hold", ST_PURGE, 1'b0);
    end
    tick(1);
    exp_fault = 1'b1;
    chk_st("wdog fire", ST_IDLE, 1'b0);
`else
    tick(16);
    chk_st("no wdog 16", ST_PURGE, 1'b0);
    tick(8);
    chk_st("no wdog 24", ST_PURGE, 1'b0);
    abort_phase("no wdog exit", ST_PURGE, 0, 1'b0);
    run_phase("no wdog settle", ST_SETTLE, ST_IDLE, 2);
`endif

    // Randomized episodes checked against the phase-sequence model
    for (int ep = 0; ep < 8; ep++) begin
      int kind;
      logic [1:0] ty;
      kind = $urandom_range(0, 4);
      ty   = 2'($urandom_range(1, 3));
      valid_start("rand", ty);
      if (kind == 1 || kind == 4) begin
        abort_phase("rand purge abort", ST_PURGE, $urandom_range(0, 8), kind == 4);
      end else begin
        run_phase("rand purge", ST_PURGE, ST_IRRIGATE, $urandom_range(GUARD_CYCLES, 10));
        if (kind == 2 || kind == 3) begin
          abort_phase("rand irr abort", ST_IRRIGATE, $urandom_range(0, 8), kind == 3);
        end else begin
          run_phase("rand irrigate", ST_IRRIGATE, ST_SETTLE, $urandom_range(GUARD_CYCLES, 10));
        end
      end
      run_phase("rand settle", ST_SETTLE, ST_IDLE, $urandom_range(GUARD_CYCLES, 10));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
